huffman_packer: RTL and testbench
=================================

# huffman_packer

Downstream stage of the Huffman encoder. Latches the code table (HC1..HC6 codes, M1..M6 length masks) when the encoder asserts code_valid, then packs a stream of symbol values 1..6 into a serial bitstream. The bitstream leaves as MSB-first bytes under a valid/ready handshake. A last-symbol flush pads the final partial byte with zeros and tags it.

## Interface
Parameters:
- ACC_W, 16, bit-accumulator width (must be ≥ 8 + MAX_CODE_LEN + 1)
- MAX_CODE_LEN, 7, longest legal code

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- code_valid  in  1  table-ready pulse from encoder
- HC1..HC6  in  8 each  code for symbol k, right-aligned
- M1..M6  in  8 each  length mask for symbol k (contiguous ones from bit 0)
- sym_valid  in  1  symbol present
- sym_data  in  8  symbol value; 1..6 legal
- sym_last  in  1  final symbol of frame
- sym_ready  out  1  symbol accepted when sym_valid & sym_ready
- out_valid  out  1  byte available
- out_data  out  8  packed byte; bit 7 = earliest bit
- out_last  out  1  final byte of frame
- out_ready  in  1  sink accepts byte
- err  out  1  one-cycle pulse: illegal symbol or zero-length code used
- busy  out  1  high outside IDLE

## Operation
- States: IDLE, PACK, FLUSH.
- IDLE:
  - On code_valid: latch HC1..HC6; compute len_k = popcount(Mk[6:0]); bits Mk[7] ignored; go PACK.
  - Table is held until the next load.
- PACK:
  - sym_ready = (bit_cnt < 8).
  - On accept of legal k with len_k > 0: acc ← (acc << len_k) | HCk[len_k-1:0]; bit_cnt += len_k. Code bits enter MSB-first.
  - Illegal symbol (0, >6) or len_k = 0: no bits added, err pulses next cycle, the symbol is still consumed.
  - Accepted with sym_last: go FLUSH.
  - code_valid ignored outside IDLE.
- Byte output (PACK and FLUSH): out_valid = (bit_cnt ≥ 8), or (state = FLUSH and bit_cnt > 0).
  - out_data = acc[bit_cnt-1 -: 8] when bit_cnt ≥ 8; otherwise remaining bits left-justified and zero-padded.
  - On out_valid & out_ready: bit_cnt -= min(8, bit_cnt).
- FLUSH:
  - sym_ready = 0.
  - out_last = out_valid & (bit_cnt ≤ 8).
  - When bit_cnt reaches 0: go IDLE. If entered with bit_cnt = 0, go IDLE next cycle and emit no byte.
- Widths: bit_cnt is 5 bits; max bit_cnt = 7 + 7 = 14 < ACC_W. Accumulator bits above bit_cnt are don't-care.

## Timing
- Reset values: state IDLE; bit_cnt 0; all outputs 0; table regs 0.
- Latency from symbol accept (cycle N) to out_valid: cycle N+1, if the total reaches 8. out_* are driven from registers.
- Symbol accept and byte pop are never simultaneous: sym_ready requires bit_cnt < 8, out_valid requires ≥ 8 in PACK.
- out_data and out_last hold stable while out_valid & !out_ready.
- Throughput: one symbol per cycle while the accumulator is below 8 bits.
- Reset mid-frame: partial bits and table discarded; returns to IDLE, waits for code_valid.

## Structure
- Package huffman_pkg:
  - NUM_SYM = 6, MAX_CODE_LEN = 7, ACC_W = 16.
  - State enum {IDLE, PACK, FLUSH}.
  - Code/length struct type.
- Sub-module huffman_code_len: combinational popcount of M[6:0] giving a 3-bit length; instanced six times at table capture.
- Everything else, including the accumulator, FSM and output mux, lives in huffman_packer.

## Test plan
- Table: HC1=0/M1=01, HC2=2/M2=03, HC3=6/M3=07, HC4=E/M4=0F, HC5=1E/M5=1F, HC6=1F/M6=1F. Symbols 1,2,3,4(last), out_ready=1 → bytes 0x5B, then 0x80 with out_last; busy drops after.
- Same table, symbols 6,6,6,6(last) → 20 bits of ones → 0xFF, 0xFF, 0xF0 (last).
- Backpressure: out_ready=0 for 5 cycles mid-stream → sym_ready low while bit_cnt ≥ 8, out_data stable, no bits lost; output identical to unstalled run.
- Illegal symbol: 1, 0x07, 2(last) → err pulse once, output 0x40 (last), packing unaffected.
- sym_data=0 with sym_last as first symbol → no byte, err pulse, return to IDLE.
- Reset asserted after 3 symbols → all outputs 0 immediately; sym_data ignored until a new code_valid; next frame packs correctly from empty.

Source files
------------

// File: rtl/huffman_pkg.sv
// Shared types and sizes for the Huffman packer slice.
package huffman_pkg;

   localparam int unsigned NUM_SYM      = 6;
   localparam int unsigned MAX_CODE_LEN = 7;
   localparam int unsigned ACC_W        = 16;
   localparam int unsigned LEN_W        = 3;
   localparam int unsigned CNT_W        = 5;

   typedef enum logic [1:0] {
      IDLE,
      PACK,
      FLUSH
   } state_e;

   // One latched table entry: right-aligned code and its bit length.
   typedef struct packed {
      logic [7:0]       code;
      logic [LEN_W-1:0] len;
   } code_entry_t;

endpackage

// File: rtl/huffman_code_len.sv
// Converts a contiguous length mask into a code length by counting its ones.
module huffman_code_len (
   input  logic [6:0] i_mask,
   output logic [2:0] o_len
);

   import huffman_pkg::*;

   // Popcount of the seven mask bits.
   always_comb begin
      o_len = '0;
      for (int i = 0; i < 7; i++) begin
         o_len = o_len + LEN_W'(i_mask[i]);
      end
   end

endmodule

// File: rtl/huffman_packer.sv
// Latches the Huffman code table, packs symbol codes MSB-first into an
// accumulator and emits the bitstream as bytes under valid/ready.
module huffman_packer #(
   parameter int unsigned ACC_W        = 16,
   parameter int unsigned MAX_CODE_LEN = 7
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       code_valid,
   input  logic [7:0] HC1,
   input  logic [7:0] HC2,
   input  logic [7:0] HC3,
   input  logic [7:0] HC4,
   input  logic [7:0] HC5,
   input  logic [7:0] HC6,
   input  logic [7:0] M1,
   input  logic [7:0] M2,
   input  logic [7:0] M3,
   input  logic [7:0] M4,
   input  logic [7:0] M5,
   input  logic [7:0] M6,
   input  logic       sym_valid,
   input  logic [7:0] sym_data,
   input  logic       sym_last,
   output logic       sym_ready,
   output logic       out_valid,
   output logic [7:0] out_data,
   output logic       out_last,
   input  logic       out_ready,
   output logic       err,
   output logic       busy
);

   import huffman_pkg::*;

   logic [7:0]       w_hc [NUM_SYM];
   logic [7:0]       w_m  [NUM_SYM];
   logic [LEN_W-1:0] w_len [NUM_SYM];
   logic             w_unused_msb;

   state_e           r_state, w_state_d;
   logic [CNT_W-1:0] r_bit_cnt, w_bit_cnt_d;
   logic [ACC_W-1:0] r_acc, w_acc_d;
   code_entry_t      r_tab [NUM_SYM];
   code_entry_t      w_tab_d [NUM_SYM];

   logic             r_sym_ready, r_out_valid, r_out_last, r_err, r_busy;
   logic [7:0]       r_out_data;
   logic             w_sym_ready_d, w_out_valid_d, w_out_last_d, w_err_d, w_busy_d;
   logic [7:0]       w_out_data_d;

   logic             w_pop, w_accept, w_sym_hit, w_sym_ok;
   logic [CNT_W-1:0] w_pop_cnt;
   logic [7:0]       w_code_mask;
   code_entry_t      w_sel;

   assign w_hc[0] = HC1;
   assign w_hc[1] = HC2;
   assign w_hc[2] = HC3;
   assign w_hc[3] = HC4;
   assign w_hc[4] = HC5;
   assign w_hc[5] = HC6;
   assign w_m[0]  = M1;
   assign w_m[1]  = M2;
   assign w_m[2]  = M3;
   assign w_m[3]  = M4;
   assign w_m[4]  = M5;
   assign w_m[5]  = M6;

   // Mask bit 7 carries no length information.
   assign w_unused_msb = ^{M1[7], M2[7], M3[7], M4[7], M5[7], M6[7]};

   for (genvar k = 0; k < NUM_SYM; k++) begin : g_len
      huffman_code_len u_code_len (
         .i_mask (w_m[k][MAX_CODE_LEN-1:0]),
         .o_len  (w_len[k])
      );
   end

   // Byte view of the accumulator: top 8 valid bits, or the remainder left-justified.
   function automatic logic [7:0] pack_byte(input logic [ACC_W-1:0] acc,
                                            input logic [CNT_W-1:0] cnt);
      logic [ACC_W-1:0] t;
      if (cnt >= CNT_W'(8)) t = acc >> (cnt - CNT_W'(8));
      else                  t = acc << (CNT_W'(8) - cnt);
      return t[7:0];
   endfunction

   // Look up the table entry for the presented symbol.
   always_comb begin
      w_sel     = '0;
      w_sym_hit = 1'b0;
      for (int k = 0; k < NUM_SYM; k++) begin
         if (sym_data == 8'(k + 1)) begin
            w_sel     = r_tab[k];
            w_sym_hit = 1'b1;
         end
      end
      w_sym_ok    = w_sym_hit && (w_sel.len != '0);
      w_code_mask = (8'd1 << w_sel.len) - 8'd1;
   end

   // Next-state for FSM, accumulator, bit count and table.
   always_comb begin
      w_state_d   = r_state;
      w_bit_cnt_d = r_bit_cnt;
      w_acc_d     = r_acc;
      w_tab_d     = r_tab;
      w_err_d     = 1'b0;
      w_pop       = r_out_valid & out_ready;
      w_accept    = sym_valid & r_sym_ready;
      w_pop_cnt   = (r_bit_cnt >= CNT_W'(8)) ? CNT_W'(8) : r_bit_cnt;

      unique case (r_state)
         IDLE: begin
            if (code_valid) begin
               for (int k = 0; k < NUM_SYM; k++) begin
                  w_tab_d[k].code = w_hc[k];
                  w_tab_d[k].len  = w_len[k];
               end
               w_bit_cnt_d = '0;
               w_state_d   = PACK;
            end
         end
         PACK: begin
            // Pop and accept are mutually exclusive by the bit_cnt threshold.
            if (w_pop) w_bit_cnt_d = r_bit_cnt - w_pop_cnt;
            if (w_accept) begin
               if (w_sym_ok) begin
                  w_acc_d     = (r_acc << w_sel.len) | ACC_W'(w_sel.code & w_code_mask);
                  w_bit_cnt_d = r_bit_cnt + CNT_W'(w_sel.len);
               end else begin
                  w_err_d = 1'b1;
               end
               if (sym_last) w_state_d = FLUSH;
            end
         end
         FLUSH: begin
            if (w_pop) w_bit_cnt_d = r_bit_cnt - w_pop_cnt;
            if (w_bit_cnt_d == '0) w_state_d = IDLE;
         end
         default: w_state_d = IDLE;
      endcase
   end

   // Registered outputs are derived from next-state values so they align with it.
   always_comb begin
      w_out_valid_d = ((w_state_d == PACK) && (w_bit_cnt_d >= CNT_W'(8))) ||
                      ((w_state_d == FLUSH) && (w_bit_cnt_d != '0));
      w_out_data_d  = w_out_valid_d ? pack_byte(w_acc_d, w_bit_cnt_d) : 8'h00;
      w_out_last_d  = w_out_valid_d && (w_state_d == FLUSH) && (w_bit_cnt_d <= CNT_W'(8));
      w_sym_ready_d = (w_state_d == PACK) && (w_bit_cnt_d < CNT_W'(8));
      w_busy_d      = (w_state_d != IDLE);
   end

   // State, datapath and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= IDLE;
         r_bit_cnt   <= '0;
         r_acc       <= '0;
         r_tab       <= '{default: '0};
         r_sym_ready <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_data  <= 8'h00;
         r_out_last  <= 1'b0;
         r_err       <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_state     <= w_state_d;
         r_bit_cnt   <= w_bit_cnt_d;
         r_acc       <= w_acc_d;
         r_tab       <= w_tab_d;
         r_sym_ready <= w_sym_ready_d;
         r_out_valid <= w_out_valid_d;
         r_out_data  <= w_out_data_d;
         r_out_last  <= w_out_last_d;
         r_err       <= w_err_d;
         r_busy      <= w_busy_d;
      end
   end

   assign sym_ready = r_sym_ready;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_last  = r_out_last;
   assign err       = r_err;
   assign busy      = r_busy;

endmodule

// File: tb/tb_huffman_packer.sv
// Directed bench for huffman_packer: table load, packing, flush, stalls,
// illegal symbols and mid-frame reset.
module tb_huffman_packer;

   logic       clk = 1'b0;
   logic       reset;
   logic       code_valid;
   logic [7:0] HC1, HC2, HC3, HC4, HC5, HC6;
   logic [7:0] M1, M2, M3, M4, M5, M6;
   logic       sym_valid;
   logic [7:0] sym_data;
   logic       sym_last;
   logic       sym_ready;
   logic       out_valid;
   logic [7:0] out_data;
   logic       out_last;
   logic       out_ready;
   logic       err;
   logic       busy;

   int checks = 0;
   int errors = 0;

   logic [7:0] got_data [$];
   logic       got_last [$];
   int         err_cnt = 0;

   huffman_packer #(
      .ACC_W        (16),
      .MAX_CODE_LEN (7)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .code_valid (code_valid),
      .HC1        (HC1),
      .HC2        (HC2),
      .HC3        (HC3),
      .HC4        (HC4),
      .HC5        (HC5),
      .HC6        (HC6),
      .M1         (M1),
      .M2         (M2),
      .M3         (M3),
      .M4         (M4),
      .M5         (M5),
      .M6         (M6),
      .sym_valid  (sym_valid),
      .sym_data   (sym_data),
      .sym_last   (sym_last),
      .sym_ready  (sym_ready),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_last   (out_last),
      .out_ready  (out_ready),
      .err        (err),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Record every byte handshake and err pulse; inputs only change just after posedge.
   always @(negedge clk) begin
      if (!reset) begin
         if (out_valid && out_ready) begin
            got_data.push_back(out_data);
            got_last.push_back(out_last);
         end
         if (err) err_cnt++;
      end
   end

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_sym(input logic [7:0] d, input logic l);
      int n = 0;
      sym_valid = 1'b1;
      sym_data  = d;
      sym_last  = l;
      @(negedge clk);
      while (!sym_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("send_ready", {15'b0, sym_ready}, 16'd1);
      @(posedge clk);
      #1;
      sym_valid = 1'b0;
      sym_data  = 8'h00;
      sym_last  = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while (busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("idle", {15'b0, busy}, 16'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic load_table();
      code_valid = 1'b1;
      @(posedge clk);
      #1;
      code_valid = 1'b0;
      check("load_busy", {15'b0, busy}, 16'd1);
      check("load_ready", {15'b0, sym_ready}, 16'd1);
   endtask

   initial begin
      int b;
      int e;
      reset      = 1'b1;
      code_valid = 1'b0;
      sym_valid  = 1'b0;
      sym_data   = 8'h00;
      sym_last   = 1'b0;
      out_ready  = 1'b1;
      HC1 = 8'h00; M1 = 8'h01;
      HC2 = 8'h02; M2 = 8'h03;
      HC3 = 8'h06; M3 = 8'h07;
      HC4 = 8'h0E; M4 = 8'h0F;
      HC5 = 8'h1E; M5 = 8'h1F;
      HC6 = 8'h1F; M6 = 8'h1F;

      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", {15'b0, out_valid}, 16'd0);
      check("rst_out_data", {8'b0, out_data}, 16'd0);
      check("rst_out_last", {15'b0, out_last}, 16'd0);
      check("rst_sym_ready", {15'b0, sym_ready}, 16'd0);
      check("rst_err", {15'b0, err}, 16'd0);
      check("rst_busy", {15'b0, busy}, 16'd0);
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Frame 1: 0 10 110 1110 -> 0x5B, 0x80(last)
      b = got_data.size(); e = err_cnt;
      load_table();
      send_sym(8'd1, 1'b0);
      send_sym(8'd2, 1'b0);
      send_sym(8'd3, 1'b0);
      send_sym(8'd4, 1'b1);
      wait_idle();
      check("f1_count", 16'(got_data.size() - b), 16'd2);
      check("f1_b0", {8'b0, got_data[b]}, 16'h5B);
      check("f1_l0", {15'b0, got_last[b]}, 16'd0);
      check("f1_b1", {8'b0, got_data[b+1]}, 16'h80);
      check("f1_l1", {15'b0, got_last[b+1]}, 16'd1);
      check("f1_err", 16'(err_cnt - e), 16'd0);

      // Frame 2: four 5-bit all-ones codes -> 0xFF, 0xFF, 0xF0(last)
      b = got_data.size();
      load_table();
      send_sym(8'd6, 1'b0);
      send_sym(8'd6, 1'b0);
      send_sym(8'd6, 1'b0);
      send_sym(8'd6, 1'b1);
      wait_idle();
      check("f2_count", 16'(got_data.size() - b), 16'd3);
      check("f2_b0", {8'b0, got_data[b]}, 16'hFF);
      check("f2_b1", {8'b0, got_data[b+1]}, 16'hFF);
      check("f2_b2", {8'b0, got_data[b+2]}, 16'hF0);
      check("f2_l1", {15'b0, got_last[b+1]}, 16'd0);
      check("f2_l2", {15'b0, got_last[b+2]}, 16'd1);

      // Backpressure: 11110 x4 -> 0xF7, 0xBD, 0xE0(last), sink stalled 5 cycles
      b = got_data.size();
      load_table();
      out_ready = 1'b0;
      send_sym(8'd5, 1'b0);
      send_sym(8'd5, 1'b0);
      sym_valid = 1'b1;
      sym_data  = 8'd5;
      sym_last  = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_valid", {15'b0, out_valid}, 16'd1);
         check("bp_data", {8'b0, out_data}, 16'hF7);
         check("bp_last", {15'b0, out_last}, 16'd0);
         check("bp_ready", {15'b0, sym_ready}, 16'd0);
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      send_sym(8'd5, 1'b0);
      send_sym(8'd5, 1'b1);
      wait_idle();
      check("bp_count", 16'(got_data.size() - b), 16'd3);
      check("bp_b0", {8'b0, got_data[b]}, 16'hF7);
      check("bp_b1", {8'b0, got_data[b+1]}, 16'hBD);
      check("bp_b2", {8'b0, got_data[b+2]}, 16'hE0);
      check("bp_l2", {15'b0, got_last[b+2]}, 16'd1);

      // Illegal symbol in the middle: 0 (skip) 10 -> 0x40(last), one err
      b = got_data.size(); e = err_cnt;
      load_table();
      send_sym(8'd1, 1'b0);
      send_sym(8'h07, 1'b0);
      send_sym(8'd2, 1'b1);
      wait_idle();
      check("ill_count", 16'(got_data.size() - b), 16'd1);
      check("ill_b0", {8'b0, got_data[b]}, 16'h40);
      check("ill_l0", {15'b0, got_last[b]}, 16'd1);
      check("ill_err", 16'(err_cnt - e), 16'd1);

      // Lone illegal last symbol: no byte, one err, back to idle
      b = got_data.size(); e = err_cnt;
      load_table();
      send_sym(8'd0, 1'b1);
      wait_idle();
      check("zero_count", 16'(got_data.size() - b), 16'd0);
      check("zero_err", 16'(err_cnt - e), 16'd1);

      // Reset after three symbols, then a clean frame: 1110 1110 -> 0xEE(last)
      load_table();
      send_sym(8'd1, 1'b0);
      send_sym(8'd2, 1'b0);
      send_sym(8'd3, 1'b0);
      reset = 1'b1;
      #1;
      check("mr_out_valid", {15'b0, out_valid}, 16'd0);
      check("mr_out_data", {8'b0, out_data}, 16'd0);
      check("mr_sym_ready", {15'b0, sym_ready}, 16'd0);
      check("mr_busy", {15'b0, busy}, 16'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      b = got_data.size();
      sym_valid = 1'b1;
      sym_data  = 8'd1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("mr_ignore_ready", {15'b0, sym_ready}, 16'd0);
         check("mr_ignore_busy", {15'b0, busy}, 16'd0);
         @(posedge clk);
         #1;
      end
      sym_valid = 1'b0;
      sym_data  = 8'h00;
      load_table();
      send_sym(8'd4, 1'b0);
      send_sym(8'd4, 1'b1);
      wait_idle();
      check("mr_count", 16'(got_data.size() - b), 16'd1);
      check("mr_b0", {8'b0, got_data[b]}, 16'hEE);
      check("mr_l0", {15'b0, got_last[b]}, 16'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
